// File: rtl/urna_pkg.sv
// urna_pkg: shared types, constants and helpers for the ballot tally core
package urna_pkg;
  typedef enum logic [1:0] {IDLE, DECODE, UPDATE, SCAN} state_t;
  typedef enum logic [1:0] {CLS_CAND, CLS_BLANK, CLS_NULL} cls_t;
  localparam logic [7:0] BLANK_CODE = 8'h00;
  localparam logic [31:0] DEF_CAND_CODES = {8'h51, 8'h17, 8'h13, 8'h12};
  function automatic logic is_bcd(input logic [7:0] code);
    return code[7:4] <= 4'd9 && code[3:0] <= 4'd9;
  endfunction
endpackage

// File: rtl/urna_max_scan.sv
// urna_max_scan: sequential running-max scan with tie detection over N counts
//   clock/reset (async, active-low)/clear (sync); start arms a scan of N cycles
//   sel: index whose count is expected on cnt this cycle
//   done: final scan cycle; winner_idx/winner_valid/tie update at that edge
module urna_max_scan #(
  parameter int N = 4,
  parameter int CNT_W = 9,
  parameter int IDX_W = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             start,
  input  logic [CNT_W-1:0] cnt,
  output logic [IDX_W-1:0] sel,
  output logic             done,
  output logic [IDX_W-1:0] winner_idx,
  output logic             winner_valid,
  output logic             tie
);
  logic run, tie_r, gt, nx_tie;
  logic [CNT_W-1:0] max_r, nx_max;
  logic [IDX_W-1:0] idx_r, nx_idx;
  // a later index wins only on strictly greater count; equal nonzero counts flag a tie
  always_comb begin
    gt = cnt > max_r;
    nx_max = gt ? cnt : max_r;
    nx_idx = gt ? sel : idx_r;
    nx_tie = gt ? 1'b0 : tie_r | (cnt == max_r && |max_r);
    done = run && sel == IDX_W'(N - 1);
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      {run, tie_r, winner_valid, tie} <= '0;
      {sel, idx_r, winner_idx, max_r} <= '0;
    end else if (clear) begin
      {run, tie_r, winner_valid, tie} <= '0;
      {sel, idx_r, winner_idx, max_r} <= '0;
    end else if (start) begin
      run <= 1'b1;
      {sel, idx_r, max_r, tie_r} <= '0;
    end else if (run) begin
      sel <= sel + 1'b1;
      max_r <= nx_max;
      idx_r <= nx_idx;
      tie_r <= nx_tie;
      if (done) begin
        run <= 1'b0;
        winner_idx <= nx_idx;
        tie <= nx_tie;
        winner_valid <= |nx_max && !nx_tie;
      end
    end
endmodule

// File: rtl/urna_tally_core.sv
// urna_tally_core: BCD vote classifier with saturating tallies and winner/tie scan
//   clock, reset (async, active-low), clear (sync), lock (refuse new votes)
//   vote_valid/vote_code/vote_ready: one two-digit BCD code per handshake
//   rd_idx/rd_count: registered candidate count read, 1-cycle latency
//   blank_cnt/null_cnt/total_cnt, winner_idx/winner_valid/tie, sat (sticky), busy
module urna_tally_core
  import urna_pkg::*;
#(
  parameter int NUM_CAND = 4,
  parameter int CNT_W = 9,
  parameter logic [NUM_CAND*8-1:0] CAND_CODES = DEF_CAND_CODES,
  parameter int IDX_W = $clog2(NUM_CAND)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             lock,
  input  logic             vote_valid,
  input  logic [7:0]       vote_code,
  output logic             vote_ready,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [CNT_W-1:0] rd_count,
  output logic [CNT_W-1:0] blank_cnt,
  output logic [CNT_W-1:0] null_cnt,
  output logic [CNT_W-1:0] total_cnt,
  output logic [IDX_W-1:0] winner_idx,
  output logic             winner_valid,
  output logic             tie,
  output logic             sat,
  output logic             busy
);
  localparam logic [CNT_W-1:0] MAX = '1;
  state_t state, nx_state;
  cls_t cls, cls_q;
  logic [7:0] code_q;
  logic [IDX_W-1:0] hit_idx, idx_q, sel;
  logic hit, done, accept;
  logic [CNT_W-1:0] tgt;
  logic [CNT_W-1:0] cnt [NUM_CAND];
  function automatic logic [CNT_W-1:0] inc(input logic [CNT_W-1:0] v);
    return v == MAX ? v : v + 1'b1;
  endfunction
  always_ff @(posedge clock or negedge reset)
    if (!reset) state <= IDLE;
    else state <= clear ? IDLE : nx_state;
  always_comb
    nx_state = state == IDLE ? (accept ? DECODE : IDLE) :
               state == DECODE ? UPDATE :
               state == UPDATE ? SCAN :
               done ? IDLE : SCAN;
  always_comb begin
    vote_ready = state == IDLE && !lock && !clear;
    accept = vote_valid && vote_ready;
    busy = state != IDLE;
  end
  // descending search so the lowest matching index is the one left standing
  always_comb begin
    hit = 1'b0;
    hit_idx = '0;
    for (int i = NUM_CAND - 1; i >= 0; i--)
      if (code_q == CAND_CODES[i*8 +: 8]) begin
        hit = 1'b1;
        hit_idx = IDX_W'(i);
      end
    cls = code_q == BLANK_CODE ? CLS_BLANK : is_bcd(code_q) && hit ? CLS_CAND : CLS_NULL;
    tgt = cls_q == CLS_CAND ? cnt[idx_q] : cls_q == CLS_BLANK ? blank_cnt : null_cnt;
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      code_q <= '0;
      cls_q <= CLS_NULL;
      idx_q <= '0;
      {blank_cnt, null_cnt, total_cnt, rd_count, sat} <= '0;
      for (int i = 0; i < NUM_CAND; i++) cnt[i] <= '0;
    end else if (clear) begin
      code_q <= '0;
      cls_q <= CLS_NULL;
      idx_q <= '0;
      {blank_cnt, null_cnt, total_cnt, rd_count, sat} <= '0;
      for (int i = 0; i < NUM_CAND; i++) cnt[i] <= '0;
    end else begin
      rd_count <= {1'b0, rd_idx} < (IDX_W+1)'(NUM_CAND) ? cnt[rd_idx] : '0;
      if (accept) code_q <= vote_code;
      if (state == DECODE) begin
        cls_q <= cls;
        idx_q <= hit_idx;
      end
      if (state == UPDATE) begin
        total_cnt <= inc(total_cnt);
        sat <= sat || total_cnt == MAX || tgt == MAX;
        if (cls_q == CLS_CAND) cnt[idx_q] <= inc(cnt[idx_q]);
        blank_cnt <= cls_q == CLS_BLANK ? inc(blank_cnt) : blank_cnt;
        null_cnt <= cls_q == CLS_NULL ? inc(null_cnt) : null_cnt;
      end
    end
  urna_max_scan #(.N(NUM_CAND), .CNT_W(CNT_W), .IDX_W(IDX_W)) u_scan (
    .clock,
    .reset,
    .clear,
    .start(state == UPDATE),
    .cnt(cnt[sel]),
    .sel,
    .done,
    .winner_idx,
    .winner_valid,
    .tie
  );
endmodule

// File: tb/tb_urna_tally_core.sv
// tb_urna_tally_core: directed and random votes on two core widths against a counting model
module tb_urna_tally_core;
  logic clock = 0, reset = 0, clear = 0, lock = 0, vote_valid = 0;
  logic [7:0] vote_code = 0;
  logic [1:0] rd_idx = 0;
  logic ready_a, ready_b, wv_a, wv_b, tie_a, tie_b, sat_a, sat_b, busy_a, busy_b;
  logic [8:0] rd_a, blank_a, null_a, total_a;
  logic [2:0] rd_b, blank_b, null_b, total_b;
  logic [1:0] widx_a, widx_b;
  int checks = 0, errors = 0;
  int mc[2][4];
  int mb[2], mn[2], mt[2];
  bit ms[2];
  int lim[2] = '{511, 7};
  byte unsigned codes[4] = '{8'h12, 8'h13, 8'h17, 8'h51};

  always #5 clock = ~clock;

  urna_tally_core dut_a (
    .clock(clock), .reset(reset), .clear(clear), .lock(lock),
    .vote_valid(vote_valid), .vote_code(vote_code), .vote_ready(ready_a),
    .rd_idx(rd_idx), .rd_count(rd_a), .blank_cnt(blank_a), .null_cnt(null_a),
    .total_cnt(total_a), .winner_idx(widx_a), .winner_valid(wv_a), .tie(tie_a),
    .sat(sat_a), .busy(busy_a)
  );
  urna_tally_core #(.CNT_W(3)) dut_b (
    .clock(clock), .reset(reset), .clear(clear), .lock(lock),
    .vote_valid(vote_valid), .vote_code(vote_code), .vote_ready(ready_b),
    .rd_idx(rd_idx), .rd_count(rd_b), .blank_cnt(blank_b), .null_cnt(null_b),
    .total_cnt(total_b), .winner_idx(widx_b), .winner_valid(wv_b), .tie(tie_b),
    .sat(sat_b), .busy(busy_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int inc(int k, int v);
    if (v == lim[k]) begin
      ms[k] = 1;
      return v;
    end
    return v + 1;
  endfunction

  task automatic model_clear;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 4; i++) mc[k][i] = 0;
      mb[k] = 0; mn[k] = 0; mt[k] = 0; ms[k] = 0;
    end
  endtask

  task automatic model_vote(input logic [7:0] c);
    int who = -1;
    if (c == 8'h00) who = -2;
    else if (c[7:4] <= 9 && c[3:0] <= 9)
      for (int i = 3; i >= 0; i--) if (codes[i] == c) who = i;
    for (int k = 0; k < 2; k++) begin
      mt[k] = inc(k, mt[k]);
      if (who == -2) mb[k] = inc(k, mb[k]);
      else if (who == -1) mn[k] = inc(k, mn[k]);
      else mc[k][who] = inc(k, mc[k][who]);
    end
  endtask

  task automatic vote(input logic [7:0] c);
    int n = 0;
    while (!ready_a && n < 40) begin
      @(negedge clock);
      n++;
    end
    chk("ready_wait", n < 40, 1);
    vote_valid = 1;
    vote_code = c;
    @(negedge clock);
    vote_valid = 0;
    vote_code = 8'($urandom);
    model_vote(c);
  endtask

  task automatic settle;
    int n = 0;
    while (busy_a && n < 40) begin
      @(negedge clock);
      n++;
    end
    chk("busy_wait", n < 40, 1);
  endtask

  task automatic vote_gap(input logic [7:0] c);
    int n = 0;
    vote(c);
    while (!ready_a && n < 40) begin
      @(negedge clock);
      n++;
    end
    chk("ready_gap", n, 6);
  endtask

  task automatic pulse_clear;
    clear = 1;
    @(negedge clock);
    clear = 0;
    model_clear();
  endtask

  task automatic check_all(input string tag);
    int mx, nm, wi;
    for (int k = 0; k < 2; k++) begin
      mx = 0; nm = 0; wi = 0;
      for (int i = 0; i < 4; i++) if (mc[k][i] > mx) begin mx = mc[k][i]; wi = i; end
      for (int i = 0; i < 4; i++) if (mc[k][i] == mx) nm++;
      chk($sformatf("%s/%0d blank", tag, k), k ? blank_b : blank_a, mb[k]);
      chk($sformatf("%s/%0d null", tag, k), k ? null_b : null_a, mn[k]);
      chk($sformatf("%s/%0d total", tag, k), k ? total_b : total_a, mt[k]);
      chk($sformatf("%s/%0d widx", tag, k), k ? widx_b : widx_a, wi);
      chk($sformatf("%s/%0d wvalid", tag, k), k ? wv_b : wv_a, mx > 0 && nm == 1);
      chk($sformatf("%s/%0d tie", tag, k), k ? tie_b : tie_a, mx > 0 && nm > 1);
      chk($sformatf("%s/%0d sat", tag, k), k ? sat_b : sat_a, ms[k]);
      chk($sformatf("%s/%0d busy", tag, k), k ? busy_b : busy_a, 0);
    end
    for (int i = 0; i < 4; i++) begin
      rd_idx = 2'(i);
      @(negedge clock);
      chk($sformatf("%s/0 rd%0d", tag, i), rd_a, mc[0][i]);
      chk($sformatf("%s/1 rd%0d", tag, i), rd_b, mc[1][i]);
    end
  endtask

  initial begin
    int r;
    logic [7:0] c;
    model_clear();
    repeat (2) @(negedge clock);
    chk("rst_busy", busy_a, 0);
    chk("rst_total", total_a, 0);
    chk("rst_rd", rd_a, 0);
    chk("rst_wvalid", wv_a, 0);
    chk("rst_sat", sat_b, 0);
    reset = 1;
    @(negedge clock);
    check_all("reset");

    vote_gap(8'h12);
    vote_gap(8'h13);
    vote_gap(8'h12);
    check_all("rate");

    pulse_clear();
    vote(8'h17); settle();
    vote(8'h51); settle();
    check_all("tie");
    vote(8'h51); settle();
    check_all("break");

    pulse_clear();
    vote(8'h00); settle();
    vote(8'h99); settle();
    vote(8'h1A); settle();
    vote(8'hF2); settle();
    check_all("blank_null");

    pulse_clear();
    repeat (9) begin vote(8'h12); settle(); end
    check_all("saturate");
    pulse_clear();
    check_all("sat_clear");

    vote(8'h13);
    lock = 1;
    settle();
    check_all("lock_done");
    vote_valid = 1;
    vote_code = 8'h12;
    repeat (5) begin
      @(negedge clock);
      chk("lock_ready", ready_a, 0);
    end
    vote_valid = 0;
    check_all("lock_frozen");
    lock = 0;
    vote(8'h12); settle();
    check_all("unlock");

    vote(8'h17);
    repeat (3) @(negedge clock);
    chk("in_scan", busy_a, 1);
    reset = 0;
    #1;
    model_clear();
    chk("arst_total", total_a, 0);
    chk("arst_busy", busy_a, 0);
    chk("arst_wvalid", wv_a, 0);
    @(negedge clock);
    reset = 1;
    @(negedge clock);
    check_all("arst");

    vote(8'h12); settle();
    vote(8'h13);
    @(negedge clock);
    chk("in_update", busy_a, 1);
    pulse_clear();
    chk("clr_total", total_a, 0);
    chk("clr_busy", busy_a, 0);
    chk("clr_wvalid", wv_a, 0);
    check_all("clr_update");

    repeat (40) begin
      r = int'($urandom_range(0, 9));
      c = r < 4 ? codes[r] : r < 6 ? 8'h00 : 8'($urandom);
      vote(c);
      settle();
      check_all($sformatf("rnd_%02h", c));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
